jtcps1_prog_sdram_if: RTL and testbench

// Sits between the PROM download writer and the SDRAM controller's programming port.

---
 rtl/jtcps1_prog_pkg.sv | 17 +
 rtl/jtcps1_prog_fifo.sv | 44 ++++
 rtl/jtcps1_prog_sdram_if.sv | 125 ++++++++++++
 tb/tb_jtcps1_prog_sdram_if.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps1_prog_pkg.sv
// Shared definitions for the PROM-download-to-SDRAM bridge: FIFO entry layout
// and the replay FSM state encoding.
package jtcps1_prog_pkg;

  localparam int PROG_AW  = 22;
  localparam int DATA_LSB = 0;
  localparam int MASK_LSB = 8;
  localparam int BANK_LSB = 10;
  localparam int ADDR_LSB = 12;
  localparam int ENTRY_W  = PROG_AW + 12;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/jtcps1_prog_fifo.sv
// Small synchronous FIFO; extra pointer MSB tells full from empty.
// Read data is taken combinationally from the head slot.
module jtcps1_prog_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0]  r_wr_ptr;
  logic [PW:0]  r_rd_ptr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[PW-1:0]];

  // Pointer update; the caller never pushes when full or pops when empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/jtcps1_prog_sdram_if.sv
// Buffers PROM download byte writes and replays them to the SDRAM programming
// port with a req/done handshake; reports when the download has drained.
module jtcps1_prog_sdram_if
  import jtcps1_prog_pkg::*;
#(
  parameter int AW    = 22,
  parameter int DEPTH = 4
) (
  input  logic          i_rst,
  input  logic          i_clk,
  input  logic          i_downloading,
  input  logic [AW-1:0] i_prog_addr,
  input  logic [7:0]    i_prog_data,
  input  logic [1:0]    i_prog_mask,
  input  logic [1:0]    i_prog_bank,
  input  logic          i_prog_we,
  output logic          o_sdram_ack,
  output logic          o_sdr_req,
  output logic [AW-1:0] o_sdr_addr,
  output logic [15:0]   o_sdr_din,
  output logic [1:0]    o_sdr_dqm,
  output logic [1:0]    o_sdr_ba,
  input  logic          i_sdr_done,
  output logic          o_dwnld_busy
);

  localparam int EW = AW + 12;

  state_t        r_state;
  state_t        w_next;
  logic          r_ack;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_din;
  logic [1:0]    r_dqm;
  logic [1:0]    r_ba;
  logic          w_full;
  logic          w_empty;
  logic          w_capture;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass;
  logic          w_load;
  logic [EW-1:0] w_din;
  logic [EW-1:0] w_dout;
  logic [EW-1:0] w_src;

  assign w_capture = i_prog_we & ~r_ack & ~w_full;
  assign w_din     = {i_prog_addr, i_prog_bank, i_prog_mask, i_prog_data};

  jtcps1_prog_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next state and FIFO pop; an empty-FIFO capture in IDLE bypasses storage
  // so ack and req rise together.
  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_bypass = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = WAIT;
        end else if (w_capture) begin
          w_bypass = 1'b1;
          w_next   = WAIT;
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        if (i_sdr_done) w_next = IDLE;
        else            w_next = WAIT;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_push = w_capture & ~w_bypass;
  assign w_load = w_pop | w_bypass;
  assign w_src  = w_pop ? w_dout : w_din;

  // State, ack pulse and SDRAM command registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_din   <= 16'h0000;
      r_dqm   <= 2'b00;
      r_ba    <= 2'b00;
    end else begin
      r_state <= w_next;
      r_ack   <= w_capture;
      if (w_load) begin
        r_req  <= 1'b1;
        r_addr <= w_src[ADDR_LSB +: AW];
        r_din  <= {2{w_src[DATA_LSB +: 8]}};
        r_dqm  <= w_src[MASK_LSB +: 2];
        r_ba   <= w_src[BANK_LSB +: 2];
      end else if (r_state == WAIT && i_sdr_done) begin
        r_req <= 1'b0;
      end
    end
  end

  assign o_sdram_ack  = r_ack;
  assign o_sdr_req    = r_req;
  assign o_sdr_addr   = r_addr;
  assign o_sdr_din    = r_din;
  assign o_sdr_dqm    = r_dqm;
  assign o_sdr_ba     = r_ba;
  assign o_dwnld_busy = ~i_rst & (i_downloading | ~w_empty | (r_state == WAIT));

endmodule

// File: tb/tb_jtcps1_prog_sdram_if.sv
// Directed bench for jtcps1_prog_sdram_if with a simple SDRAM controller model.
module tb_jtcps1_prog_sdram_if;

  localparam int AW = 22;

  logic          clk;
  logic          rst;
  logic          downloading;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [1:0]    prog_mask;
  logic [1:0]    prog_bank;
  logic          prog_we;
  logic          sdram_ack;
  logic          sdr_req;
  logic [AW-1:0] sdr_addr;
  logic [15:0]   sdr_din;
  logic [1:0]    sdr_dqm;
  logic [1:0]    sdr_ba;
  logic          sdr_done_m;
  logic          stray_done;
  logic          dwnld_busy;

  int n_cmp;
  int n_fail;
  int done_delay;
  int wait_cnt;
  logic req_seen;
  logic [AW+19:0] log_q[$];

  jtcps1_prog_sdram_if #(.AW(AW), .DEPTH(4)) dut (
    .i_rst         (rst),
    .i_clk         (clk),
    .i_downloading (downloading),
    .i_prog_addr   (prog_addr),
    .i_prog_data   (prog_data),
    .i_prog_mask   (prog_mask),
    .i_prog_bank   (prog_bank),
    .i_prog_we     (prog_we),
    .o_sdram_ack   (sdram_ack),
    .o_sdr_req     (sdr_req),
    .o_sdr_addr    (sdr_addr),
    .o_sdr_din     (sdr_din),
    .o_sdr_dqm     (sdr_dqm),
    .o_sdr_ba      (sdr_ba),
    .i_sdr_done    (sdr_done_m | stray_done),
    .o_dwnld_busy  (dwnld_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDRAM controller model: logs each new request, answers after done_delay cycles.
  initial begin
    sdr_done_m = 1'b0;
    req_seen   = 1'b0;
    wait_cnt   = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        sdr_done_m = 1'b0;
        req_seen   = 1'b0;
      end else if (sdr_done_m) begin
        sdr_done_m = 1'b0;
        req_seen   = 1'b0;
      end else if (sdr_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          wait_cnt = 0;
          log_q.push_back({sdr_addr, sdr_din, sdr_dqm, sdr_ba});
        end else begin
          wait_cnt++;
        end
        if (wait_cnt >= done_delay) sdr_done_m = 1'b1;
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d,
                          input logic [1:0] m, input logic [1:0] b, output int waited);
    prog_addr = a;
    prog_data = d;
    prog_mask = m;
    prog_bank = b;
    prog_we   = 1'b1;
    waited    = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      waited++;
      if (sdram_ack) break;
    end
    prog_we = 1'b0;
    if (!sdram_ack) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: no ack after %0d cycles, required ack within 200", waited);
    end
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (!dwnld_busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: dwnld_busy=1 after 500 cycles, required 0");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    downloading = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (sdram_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", sdram_ack); end
    n_cmp++; if (sdr_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", sdr_req); end
    n_cmp++; if (sdr_addr !== 22'h000000) begin n_fail++; $display("FAIL rst_addr: got %h want 0", sdr_addr); end
    n_cmp++; if (sdr_din !== 16'h0000) begin n_fail++; $display("FAIL rst_din: got %h want 0", sdr_din); end
    n_cmp++; if ({sdr_dqm, sdr_ba} !== 4'b0000) begin n_fail++; $display("FAIL rst_dqm_ba: got %b want 0000", {sdr_dqm, sdr_ba}); end
    n_cmp++; if (dwnld_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", dwnld_busy); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int w;
    done_delay  = 3;
    downloading = 1'b1;
    do_write(22'h000123, 8'hA5, 2'b10, 2'b01, w);
    n_cmp++; if (w !== 1) begin n_fail++; $display("FAIL single_latency: ack after %0d cycles, want 1", w); end
    n_cmp++; if (sdr_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b want 1", sdr_req); end
    n_cmp++; if (sdr_addr !== 22'h000123) begin n_fail++; $display("FAIL single_addr: got %h want 000123", sdr_addr); end
    n_cmp++; if (sdr_din !== 16'hA5A5) begin n_fail++; $display("FAIL single_din: got %h want a5a5", sdr_din); end
    n_cmp++; if (sdr_dqm !== 2'b10) begin n_fail++; $display("FAIL single_dqm: got %b want 10", sdr_dqm); end
    n_cmp++; if (sdr_ba !== 2'b01) begin n_fail++; $display("FAIL single_ba: got %b want 01", sdr_ba); end
    @(posedge clk); #1;
    n_cmp++; if (sdram_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0", sdram_ack); end
    n_cmp++; if (dwnld_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_inflight: got %b want 1", dwnld_busy); end
    for (int c = 0; c < 50; c++) begin
      if (!sdr_req) break;
      @(posedge clk); #1;
    end
    downloading = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (dwnld_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", dwnld_busy); end
    wait_idle();
  endtask

  task automatic test_held();
    int base;
    int acks;
    base = log_q.size();
    done_delay  = 2;
    downloading = 1'b1;
    prog_addr = 22'h2AAAAA;
    prog_data = 8'h3C;
    prog_mask = 2'b01;
    prog_bank = 2'b11;
    prog_we   = 1'b1;
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (sdram_ack) acks++;
    end
    prog_we = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (sdram_ack) acks++;
    end
    downloading = 1'b0;
    wait_idle();
    n_cmp++; if (acks !== 1) begin n_fail++; $display("FAIL held_acks: got %0d want 1", acks); end
    n_cmp++; if (log_q.size() - base !== 1) begin n_fail++; $display("FAIL held_entries: got %0d want 1", log_q.size() - base); end
    if (log_q.size() > base) begin
      n_cmp++;
      if (log_q[base] !== {22'h2AAAAA, 16'h3C3C, 2'b01, 2'b11}) begin
        n_fail++; $display("FAIL held_entry: got %h want %h", log_q[base], {22'h2AAAAA, 16'h3C3C, 2'b01, 2'b11});
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int w;
    int max_w;
    logic [AW-1:0]  a;
    logic [7:0]     d;
    logic [1:0]     m;
    logic [1:0]     b;
    logic [AW+19:0] exp_e;
    base = log_q.size();
    done_delay  = 10;
    downloading = 1'b1;
    max_w = 0;
    for (int i = 0; i < 8; i++) begin
      a = 22'h010000 + 22'(i * 3);
      d = 8'h10 + 8'(i * 17);
      m = (i % 2 == 0) ? 2'b10 : 2'b01;
      b = 2'(i % 4);
      do_write(a, d, m, b, w);
      if (w > max_w) max_w = w;
    end
    downloading = 1'b0;
    wait_idle();
    n_cmp++; if (max_w < 3) begin n_fail++; $display("FAIL b2b_stall: max ack wait %0d cycles, want >= 3", max_w); end
    n_cmp++; if (log_q.size() - base !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", log_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      a = 22'h010000 + 22'(i * 3);
      d = 8'h10 + 8'(i * 17);
      m = (i % 2 == 0) ? 2'b10 : 2'b01;
      b = 2'(i % 4);
      exp_e = {a, d, d, m, b};
      if (base + i < log_q.size()) begin
        n_cmp++;
        if (log_q[base + i] !== exp_e) begin
          n_fail++; $display("FAIL b2b_entry%0d: got %h want %h", i, log_q[base + i], exp_e);
        end
      end
    end
  endtask

  task automatic test_drain();
    int w;
    int seen;
    int viol;
    logic fell;
    done_delay  = 12;
    downloading = 1'b1;
    do_write(22'h000200, 8'h01, 2'b10, 2'b00, w);
    do_write(22'h000201, 8'h02, 2'b01, 2'b00, w);
    do_write(22'h000202, 8'h03, 2'b10, 2'b00, w);
    downloading = 1'b0;
    seen = 0;
    viol = 0;
    fell = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (seen == 3) begin
        fell = ~dwnld_busy;
        break;
      end
      if (!dwnld_busy) viol++;
      if (sdr_done_m) seen++;
    end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL drain_busy_held: busy low %0d cycles early, want 0", viol); end
    n_cmp++; if (seen !== 3) begin n_fail++; $display("FAIL drain_dones: got %0d want 3", seen); end
    n_cmp++; if (fell !== 1'b1) begin n_fail++; $display("FAIL drain_busy_fall: busy=%b after last done, want 0", ~fell); end
    wait_idle();
  endtask

  task automatic test_async_rst();
    int base;
    int w;
    int bad;
    done_delay  = 40;
    downloading = 1'b1;
    base = log_q.size();
    do_write(22'h000300, 8'h11, 2'b10, 2'b10, w);
    do_write(22'h000301, 8'h22, 2'b01, 2'b10, w);
    do_write(22'h000302, 8'h33, 2'b10, 2'b10, w);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (sdr_req !== 1'b0) begin n_fail++; $display("FAIL arst_req: got %b want 0", sdr_req); end
    n_cmp++; if (sdram_ack !== 1'b0) begin n_fail++; $display("FAIL arst_ack: got %b want 0", sdram_ack); end
    downloading = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_delay = 3;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (sdr_req || dwnld_busy) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL arst_stale: req/busy high %0d cycles, want 0", bad); end
    n_cmp++; if (log_q.size() - base !== 1) begin n_fail++; $display("FAIL arst_issued: got %0d writes want 1", log_q.size() - base); end
  endtask

  task automatic test_stray_done();
    int base;
    int w;
    base = log_q.size();
    downloading = 1'b0;
    stray_done  = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (sdr_req !== 1'b0) begin n_fail++; $display("FAIL stray_req: got %b want 0", sdr_req); end
    n_cmp++; if (dwnld_busy !== 1'b0) begin n_fail++; $display("FAIL stray_busy: got %b want 0", dwnld_busy); end
    n_cmp++; if (log_q.size() !== base) begin n_fail++; $display("FAIL stray_issue: got %0d writes want 0", log_q.size() - base); end
    do_write(22'h3FFFFF, 8'hC3, 2'b01, 2'b10, w);
    wait_idle();
    n_cmp++; if (log_q.size() - base !== 1) begin n_fail++; $display("FAIL stray_after_count: got %0d want 1", log_q.size() - base); end
    if (log_q.size() > base) begin
      n_cmp++;
      if (log_q[base] !== {22'h3FFFFF, 16'hC3C3, 2'b01, 2'b10}) begin
        n_fail++; $display("FAIL stray_after_entry: got %h want %h", log_q[base], {22'h3FFFFF, 16'hC3C3, 2'b01, 2'b10});
      end
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    done_delay  = 3;
    rst         = 1'b1;
    downloading = 1'b0;
    prog_addr   = '0;
    prog_data   = 8'h00;
    prog_mask   = 2'b11;
    prog_bank   = 2'b00;
    prog_we     = 1'b0;
    stray_done  = 1'b0;
    test_reset();
    test_single();
    test_held();
    test_back_to_back();
    test_drain();
    test_async_rst();
    test_stray_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
